// File: rtl/upcounter_pkg.sv
// rtl/upcounter_pkg.sv - shared state encoding and reset defaults for the up-counter sequencer
package upcounter_pkg;

    localparam logic [25:0] DEF_DIV   = 26'd50000000;
    localparam logic [3:0]  DEF_LIMIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_e;

endpackage

// File: rtl/upcounter_ctrl_if.sv
// rtl/upcounter_ctrl_if.sv - config, command and status bundle of the up-counter sequencer
interface upcounter_ctrl_if #(
    parameter int DIV_W = 26,
    parameter int CNT_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [DIV_W-1:0] cfg_div;
    logic [CNT_W-1:0] cfg_limit;
    logic             cmd_start;
    logic             cmd_stop;
    logic             cmd_step;
    logic             cmd_clr;
    logic             tick;
    logic [CNT_W-1:0] count;
    logic             wrap;
    logic [1:0]       state;

    modport master (
        output cfg_valid, cfg_div, cfg_limit, cmd_start, cmd_stop, cmd_step, cmd_clr,
        input  cfg_ready, tick, count, wrap, state
    );

    modport slave (
        input  cfg_valid, cfg_div, cfg_limit, cmd_start, cmd_stop, cmd_step, cmd_clr,
        output cfg_ready, tick, count, wrap, state
    );
endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-div_i cycle counter; hit_o flags the last cycle of each period
module tick_prescaler #(
    parameter int DIV_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic             hit_o
);
    logic [DIV_W-1:0] cnt_q, cnt_d;

    // div_i is never 0 (the controller stores 0 as 1), so div_i-1 is always a valid count
    assign hit_o = en_i && !clr_i && (cnt_q == div_i - DIV_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (hit_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/upcounter_ctrl.sv
// rtl/upcounter_ctrl.sv - run/stop/single-step sequencer with programmable tick and bounded up-count
module upcounter_ctrl
    import upcounter_pkg::*;
#(
    parameter int               DIV_W     = 26,
    parameter int               CNT_W     = 4,
    parameter logic [DIV_W-1:0] DEF_DIV   = upcounter_pkg::DEF_DIV,
    parameter logic [CNT_W-1:0] DEF_LIMIT = upcounter_pkg::DEF_LIMIT
) (
    input  logic             clk,
    input  logic             rstn,
    upcounter_ctrl_if.slave  bus
);
    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [CNT_W-1:0] lim_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, wrap_q, wrap_d;
    logic             cfg_ready_q;
    logic             cfg_fire;
    logic             presc_en;
    logic             hit;

    // A stop in the same cycle as a period end suppresses that tick
    assign presc_en = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !bus.cmd_stop;
    assign cfg_fire = bus.cfg_valid && cfg_ready_q;

    tick_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk   (clk),
        .rst   (rstn),
        .div_i (div_q),
        .clr_i (1'b0),
        .en_i  (presc_en),
        .hit_o (hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!bus.cmd_stop) begin
                    if (bus.cmd_start) begin
                        state_d = ST_RUN;
                    end else if (bus.cmd_step) begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_RUN: begin
                if (bus.cmd_stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_STEP: begin
                if (bus.cmd_stop || hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (hit) begin
            if (count_q >= lim_q) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
        if (bus.cmd_clr) begin
            count_d = '0;
            wrap_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q     <= ST_IDLE;
            div_q       <= DEF_DIV;
            lim_q       <= DEF_LIMIT;
            count_q     <= '0;
            tick_q      <= 1'b0;
            wrap_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            tick_q      <= hit;
            wrap_q      <= wrap_d;
            cfg_ready_q <= (state_d == ST_IDLE);
            if (cfg_fire) begin
                div_q <= (bus.cfg_div == '0) ? DIV_W'(1) : bus.cfg_div;
                lim_q <= bus.cfg_limit;
            end
        end
    end

    assign bus.cfg_ready = cfg_ready_q;
    assign bus.tick      = tick_q;
    assign bus.count     = count_q;
    assign bus.wrap      = wrap_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_upcounter_ctrl.sv
// tb/tb_upcounter_ctrl.sv - directed self-checking bench for upcounter_ctrl
module tb_upcounter_ctrl;
    logic clk = 1'b0;
    logic rstn;
    int   n_asserts = 0;
    int   n_fail    = 0;

    upcounter_ctrl_if #(.DIV_W(26), .CNT_W(4)) bus ();

    upcounter_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input int gap, input logic [3:0] exp_cnt, input logic exp_wrap);
        for (int i = 0; i < gap - 1; i++) begin
            step();
            chk("no_tick_mid_period", {31'd0, bus.tick}, 32'd0);
        end
        step();
        chk("tick", {31'd0, bus.tick}, 32'd1);
        chk("count", {28'd0, bus.count}, {28'd0, exp_cnt});
        chk("wrap", {31'd0, bus.wrap}, {31'd0, exp_wrap});
    endtask

    task automatic cfg_write(input logic [25:0] div, input logic [3:0] lim);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = div;
        bus.cfg_limit = lim;
        step();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.cmd_start = 1'b1;
        step();
        bus.cmd_start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.cmd_stop = 1'b1;
        step();
        bus.cmd_stop = 1'b0;
    endtask

    initial begin
        rstn          = 1'b1;
        bus.cfg_valid = 1'b0;
        bus.cfg_div   = '0;
        bus.cfg_limit = '0;
        bus.cmd_start = 1'b0;
        bus.cmd_stop  = 1'b0;
        bus.cmd_step  = 1'b0;
        bus.cmd_clr   = 1'b0;

        // Reset held 3 cycles
        repeat (3) step();
        chk("rst_state", {30'd0, bus.state}, 32'd0);
        chk("rst_count", {28'd0, bus.count}, 32'd0);
        chk("rst_tick", {31'd0, bus.tick}, 32'd0);
        chk("rst_wrap", {31'd0, bus.wrap}, 32'd0);
        chk("rst_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
        rstn = 1'b0;
        step();

        // div=4 limit=3 continuous run: 1,2,3,0(wrap)
        cfg_write(26'd4, 4'd3);
        pulse_start();
        chk("run_state", {30'd0, bus.state}, 32'd1);
        chk("run_cfg_ready", {31'd0, bus.cfg_ready}, 32'd0);
        wait_tick(4, 4'd1, 1'b0);
        wait_tick(4, 4'd2, 1'b0);
        wait_tick(4, 4'd3, 1'b0);
        wait_tick(4, 4'd0, 1'b1);
        step();
        chk("wrap_one_cycle", {31'd0, bus.wrap}, 32'd0);

        // Stop two cycles into a period, then restart
        step();
        pulse_stop();
        chk("stop_state", {30'd0, bus.state}, 32'd0);
        chk("stop_tick", {31'd0, bus.tick}, 32'd0);
        chk("stop_count_held", {28'd0, bus.count}, 32'd0);
        chk("stop_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("idle_no_tick", {31'd0, bus.tick}, 32'd0);
        end
        pulse_start();
        wait_tick(4, 4'd1, 1'b0);
        pulse_stop();
        chk("stop2_count", {28'd0, bus.count}, 32'd1);

        // Single step with div=3
        cfg_write(26'd3, 4'd3);
        bus.cmd_clr = 1'b1;
        step();
        bus.cmd_clr = 1'b0;
        chk("clr_count", {28'd0, bus.count}, 32'd0);
        chk("clr_no_tick", {31'd0, bus.tick}, 32'd0);
        bus.cmd_step = 1'b1;
        step();
        bus.cmd_step = 1'b0;
        chk("step_state", {30'd0, bus.state}, 32'd2);
        wait_tick(3, 4'd1, 1'b0);
        chk("step_back_idle", {30'd0, bus.state}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("step_single", {31'd0, bus.tick}, 32'd0);
        end
        bus.cmd_step = 1'b1;
        step();
        bus.cmd_step = 1'b0;
        wait_tick(3, 4'd2, 1'b0);

        // div=1 limit=2: tick every cycle, clear wins over a wrapping tick
        cfg_write(26'd1, 4'd2);
        bus.cmd_clr = 1'b1;
        step();
        bus.cmd_clr = 1'b0;
        pulse_start();
        wait_tick(1, 4'd1, 1'b0);
        wait_tick(1, 4'd2, 1'b0);
        wait_tick(1, 4'd0, 1'b1);
        wait_tick(1, 4'd1, 1'b0);
        wait_tick(1, 4'd2, 1'b0);
        bus.cmd_clr = 1'b1;
        wait_tick(1, 4'd0, 1'b0);
        bus.cmd_clr = 1'b0;
        wait_tick(1, 4'd1, 1'b0);
        pulse_stop();
        chk("stop_vs_tick", {31'd0, bus.tick}, 32'd0);
        chk("stop_vs_tick_cnt", {28'd0, bus.count}, 32'd1);

        // cfg_div=0 acts as 1; config during RUN ignored
        cfg_write(26'd0, 4'd9);
        pulse_start();
        wait_tick(1, 4'd2, 1'b0);
        wait_tick(1, 4'd3, 1'b0);
        bus.cfg_valid = 1'b1;
        bus.cfg_div   = 26'd7;
        bus.cfg_limit = 4'd1;
        wait_tick(1, 4'd4, 1'b0);
        bus.cfg_valid = 1'b0;
        pulse_stop();
        pulse_start();
        wait_tick(1, 4'd5, 1'b0);
        pulse_stop();

        // Limit lowered below current count: next increment wraps
        cfg_write(26'd2, 4'd2);
        bus.cmd_step = 1'b1;
        step();
        bus.cmd_step = 1'b0;
        wait_tick(2, 4'd0, 1'b1);

        // Reset in the middle of RUN
        pulse_start();
        step();
        rstn = 1'b1;
        step();
        chk("rst_run_state", {30'd0, bus.state}, 32'd0);
        chk("rst_run_cfg_ready", {31'd0, bus.cfg_ready}, 32'd1);
        chk("rst_run_tick", {31'd0, bus.tick}, 32'd0);
        rstn = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
